// File: rtl/rs_param_if.sv
// Dispatch, result-bus and issue signals of the reservation station.
// The station itself connects through the slave modport; the dispatch stage,
// result buses and execution unit side connect through the master modport.
interface rs_param_if #(
    parameter int ENTRIES = 8,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6,
    parameter int CDB_N   = 2
);
    localparam int CNT_W = $clog2(ENTRIES + 1);

    logic                      flush;
    logic                      in_valid;
    logic [OP_W-1:0]           in_op;
    logic [DATA_W-1:0]         in_imm;
    logic [DATA_W-1:0]         in_pc;
    logic [ROB_W-1:0]          in_Qj;
    logic [ROB_W-1:0]          in_Qk;
    logic [DATA_W-1:0]         in_Vj;
    logic [DATA_W-1:0]         in_Vk;
    logic [ROB_W-1:0]          in_rd_rob;
    logic                      in_has_rd_dest;
    logic [CDB_N-1:0]          cdb_valid;
    logic [CDB_N*ROB_W-1:0]    cdb_tag;
    logic [CDB_N*DATA_W-1:0]   cdb_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [OP_W-1:0]           out_op;
    logic [DATA_W-1:0]         out_Vj;
    logic [DATA_W-1:0]         out_Vk;
    logic [DATA_W-1:0]         out_imm;
    logic [DATA_W-1:0]         out_pc;
    logic [ROB_W-1:0]          out_rob_tag;
    logic                      has_capacity;
    logic [CNT_W-1:0]          count;

    modport master (
        output flush, in_valid, in_op, in_imm, in_pc, in_Qj, in_Qk, in_Vj, in_Vk,
               in_rd_rob, in_has_rd_dest, cdb_valid, cdb_tag, cdb_data, out_ready,
        input  out_valid, out_op, out_Vj, out_Vk, out_imm, out_pc, out_rob_tag,
               has_capacity, count
    );

    modport slave (
        input  flush, in_valid, in_op, in_imm, in_pc, in_Qj, in_Qk, in_Vj, in_Vk,
               in_rd_rob, in_has_rd_dest, cdb_valid, cdb_tag, cdb_data, out_ready,
        output out_valid, out_op, out_Vj, out_Vk, out_imm, out_pc, out_rob_tag,
               has_capacity, count
    );
endinterface

// File: rtl/rs_param.sv
// Parametrised reservation station: buffers decoded operations, resolves
// operand tags from the result buses (including at dispatch), and issues the
// oldest ready operation through a valid/ready output register.
module rs_param #(
    parameter int ENTRIES = 8,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6,
    parameter int CDB_N   = 2
) (
    input logic       clk,
    input logic       rst,
    rs_param_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES + 1);

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } snoop_t;

    // Entry storage; age_q[i][j] set means entry i is older than entry j.
    logic [ENTRIES-1:0] busy_q, busy_d;
    logic [OP_W-1:0]    op_q   [ENTRIES];
    logic [OP_W-1:0]    op_d   [ENTRIES];
    logic [ROB_W-1:0]   qj_q   [ENTRIES];
    logic [ROB_W-1:0]   qj_d   [ENTRIES];
    logic [ROB_W-1:0]   qk_q   [ENTRIES];
    logic [ROB_W-1:0]   qk_d   [ENTRIES];
    logic [DATA_W-1:0]  vj_q   [ENTRIES];
    logic [DATA_W-1:0]  vj_d   [ENTRIES];
    logic [DATA_W-1:0]  vk_q   [ENTRIES];
    logic [DATA_W-1:0]  vk_d   [ENTRIES];
    logic [DATA_W-1:0]  imm_q  [ENTRIES];
    logic [DATA_W-1:0]  imm_d  [ENTRIES];
    logic [DATA_W-1:0]  pc_q   [ENTRIES];
    logic [DATA_W-1:0]  pc_d   [ENTRIES];
    logic [ROB_W-1:0]   rob_q  [ENTRIES];
    logic [ROB_W-1:0]   rob_d  [ENTRIES];
    logic [ENTRIES-1:0] age_q  [ENTRIES];
    logic [ENTRIES-1:0] age_d  [ENTRIES];

    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_valid_q, out_valid_d;
    logic [OP_W-1:0]    out_op_q, out_op_d;
    logic [DATA_W-1:0]  out_vj_q, out_vj_d, out_vk_q, out_vk_d;
    logic [DATA_W-1:0]  out_imm_q, out_imm_d, out_pc_q, out_pc_d;
    logic [ROB_W-1:0]   out_rob_q, out_rob_d;

    logic [ENTRIES-1:0] ready, oldest;
    logic [IDX_W-1:0]   free_idx, issue_idx;
    logic               has_capacity, accept, issue;
    snoop_t             wake_j [ENTRIES];
    snoop_t             wake_k [ENTRIES];
    snoop_t             disp_j, disp_k;

    // Match a nonzero tag against the valid buses; lowest bus index wins.
    function automatic snoop_t snoop(input logic [ROB_W-1:0]        tag,
                                     input logic [CDB_N-1:0]        valid,
                                     input logic [CDB_N*ROB_W-1:0]  tags,
                                     input logic [CDB_N*DATA_W-1:0] data);
        snoop_t r;
        r = '0;
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (valid[k] && tag != '0 && tags[k*ROB_W +: ROB_W] == tag) begin
                r.hit  = 1'b1;
                r.data = data[k*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    assign has_capacity = (count_q < CNT_W'(ENTRIES));
    assign accept       = bus.in_valid && has_capacity && !bus.flush;
    assign issue        = (|ready) && (!out_valid_q || bus.out_ready) && !bus.flush;
    assign disp_j       = snoop(bus.in_Qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    assign disp_k       = snoop(bus.in_Qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

    // Per-entry readiness, bus snoop results and lowest free slot.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            ready[i]  = busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0;
            wake_j[i] = snoop(qj_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            wake_k[i] = snoop(qk_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            if (!busy_q[i]) free_idx = IDX_W'(i);
        end
    end

    // Oldest-ready selection: a ready entry loses if any other ready entry is older.
    always_comb begin
        oldest    = ready;
        issue_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (j != i && ready[j] && !age_q[i][j]) oldest[i] = 1'b0;
            end
            if (oldest[i]) issue_idx = IDX_W'(i);
        end
    end

    // Entry next state: wakeup, issue-free, dispatch with bypass, flush.
    always_comb begin
        busy_d = busy_q;  op_d  = op_q;   qj_d = qj_q;  qk_d = qk_q;
        vj_d   = vj_q;    vk_d  = vk_q;   imm_d = imm_q; pc_d = pc_q;
        rob_d  = rob_q;   age_d = age_q;
        for (int i = 0; i < ENTRIES; i++) begin
            if (busy_q[i] && wake_j[i].hit) begin
                qj_d[i] = '0;
                vj_d[i] = wake_j[i].data;
            end
            if (busy_q[i] && wake_k[i].hit) begin
                qk_d[i] = '0;
                vk_d[i] = wake_k[i].data;
            end
        end
        if (issue) busy_d[issue_idx] = 1'b0;
        if (accept) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = bus.in_op;
            qj_d[free_idx]   = disp_j.hit ? '0 : bus.in_Qj;
            vj_d[free_idx]   = disp_j.hit ? disp_j.data : bus.in_Vj;
            qk_d[free_idx]   = disp_k.hit ? '0 : bus.in_Qk;
            vk_d[free_idx]   = disp_k.hit ? disp_k.data : bus.in_Vk;
            imm_d[free_idx]  = bus.in_imm;
            pc_d[free_idx]   = bus.in_pc;
            rob_d[free_idx]  = bus.in_has_rd_dest ? bus.in_rd_rob : '0;
            for (int j = 0; j < ENTRIES; j++) begin
                age_d[free_idx][j] = 1'b0;
                age_d[j][free_idx] = busy_q[j];
            end
        end
        if (bus.flush) busy_d = '0;
    end

    // Output register next state: load on issue, drop on consume or flush.
    always_comb begin
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_vj_d    = out_vj_q;
        out_vk_d    = out_vk_q;
        out_imm_d   = out_imm_q;
        out_pc_d    = out_pc_q;
        out_rob_d   = out_rob_q;
        count_d     = count_q + CNT_W'(accept) - CNT_W'(issue);
        if (bus.flush) begin
            out_valid_d = 1'b0;
            count_d     = '0;
        end else if (issue) begin
            out_valid_d = 1'b1;
            out_op_d    = op_q[issue_idx];
            out_vj_d    = vj_q[issue_idx];
            out_vk_d    = vk_q[issue_idx];
            out_imm_d   = imm_q[issue_idx];
            out_pc_d    = pc_q[issue_idx];
            out_rob_d   = rob_q[issue_idx];
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            busy_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_vj_q    <= '0;
            out_vk_q    <= '0;
            out_imm_q   <= '0;
            out_pc_q    <= '0;
            out_rob_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_vj_q    <= out_vj_d;
            out_vk_q    <= out_vk_d;
            out_imm_q   <= out_imm_d;
            out_pc_q    <= out_pc_d;
            out_rob_q   <= out_rob_d;
        end
    end

    // Entry payload and age matrix storage.
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; busy_q gates every use, so stale contents are never observed.
        op_q  <= op_d;  qj_q <= qj_d;  qk_q  <= qk_d;  vj_q <= vj_d;  vk_q  <= vk_d;
        imm_q <= imm_d; pc_q <= pc_d;  rob_q <= rob_d; age_q <= age_d;
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_op       = out_op_q;
    assign bus.out_Vj       = out_vj_q;
    assign bus.out_Vk       = out_vk_q;
    assign bus.out_imm      = out_imm_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_rob_tag  = out_rob_q;
    assign bus.has_capacity = has_capacity;
    assign bus.count        = count_q;
endmodule

// File: tb/tb_rs_param.sv
// Directed testbench for rs_param with hand-computed expected values.
module tb_rs_param;
    localparam int ENTRIES = 8;
    localparam int DATA_W  = 32;
    localparam int ROB_W   = 4;
    localparam int OP_W    = 6;
    localparam int CDB_N   = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rs_param_if #(.ENTRIES(ENTRIES), .DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W), .CDB_N(CDB_N)) bus ();

    rs_param #(.ENTRIES(ENTRIES), .DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W), .CDB_N(CDB_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush          = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_op          = '0;
        bus.in_imm         = '0;
        bus.in_pc          = '0;
        bus.in_Qj          = '0;
        bus.in_Qk          = '0;
        bus.in_Vj          = '0;
        bus.in_Vk          = '0;
        bus.in_rd_rob      = '0;
        bus.in_has_rd_dest = 1'b0;
        bus.cdb_valid      = '0;
        bus.cdb_tag        = '0;
        bus.cdb_data       = '0;
    endtask

    task automatic disp(input int op, input int qj, input int qk, input int vj, input int vk,
                        input int imm, input int pc, input int rd, input bit has_rd);
        bus.in_valid       = 1'b1;
        bus.in_op          = OP_W'(op);
        bus.in_Qj          = ROB_W'(qj);
        bus.in_Qk          = ROB_W'(qk);
        bus.in_Vj          = DATA_W'(vj);
        bus.in_Vk          = DATA_W'(vk);
        bus.in_imm         = DATA_W'(imm);
        bus.in_pc          = DATA_W'(pc);
        bus.in_rd_rob      = ROB_W'(rd);
        bus.in_has_rd_dest = has_rd;
    endtask

    task automatic set_cdb(input int k, input int tag, input int data);
        bus.cdb_valid[k]                  = 1'b1;
        bus.cdb_tag[k*ROB_W +: ROB_W]     = ROB_W'(tag);
        bus.cdb_data[k*DATA_W +: DATA_W]  = DATA_W'(data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b0;
        idle();
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_op", bus.out_op, 0);
        check("rst_out_vj", bus.out_Vj, 0);
        check("rst_out_rob", bus.out_rob_tag, 0);
        check("rst_count", bus.count, 0);
        check("rst_has_cap", bus.has_capacity, 1);

        // Simple ready dispatch issues on the following edge.
        bus.out_ready = 1'b1;
        disp(1, 0, 0, 5, 7, 'h10, 'h400, 5, 1);
        step();
        idle();
        check("t1_count_after_disp", bus.count, 1);
        check("t1_valid_after_disp", bus.out_valid, 0);
        step();
        check("t1_out_valid", bus.out_valid, 1);
        check("t1_out_op", bus.out_op, 1);
        check("t1_out_vj", bus.out_Vj, 5);
        check("t1_out_vk", bus.out_Vk, 7);
        check("t1_out_imm", bus.out_imm, 'h10);
        check("t1_out_pc", bus.out_pc, 'h400);
        check("t1_out_rob", bus.out_rob_tag, 5);
        check("t1_count", bus.count, 0);
        step();
        check("t1_drain", bus.out_valid, 0);

        // Blocked Qj woken by bus 1; no destination gives rob tag 0.
        disp(2, 3, 0, 0, 2, 0, 0, 6, 0);
        step();
        idle();
        step();
        check("t2_blocked", bus.out_valid, 0);
        set_cdb(1, 3, 'h1234);
        step();
        idle();
        check("t2_wake_not_yet", bus.out_valid, 0);
        step();
        check("t2_out_valid", bus.out_valid, 1);
        check("t2_out_vj", bus.out_Vj, 'h1234);
        check("t2_out_vk", bus.out_Vk, 2);
        check("t2_out_rob_zero", bus.out_rob_tag, 0);
        step();
        check("t2_drain", bus.out_valid, 0);

        // Dispatch-time bypass on Qk; lowest bus wins on duplicate tags.
        disp(3, 0, 4, 1, 0, 0, 0, 7, 1);
        set_cdb(0, 4, 9);
        set_cdb(1, 4, 'h77);
        step();
        idle();
        check("t3_count", bus.count, 1);
        step();
        check("t3_out_valid", bus.out_valid, 1);
        check("t3_out_vk_bypass", bus.out_Vk, 9);
        check("t3_out_vj", bus.out_Vj, 1);
        step();
        check("t3_drain", bus.out_valid, 0);

        // Hold a ready op in the stalled output, then fill all entries blocked.
        bus.out_ready = 1'b0;
        disp('h3F, 0, 0, 'h55, 'h66, 'h77, 'h88, 15, 1);
        step();
        for (int i = 0; i < ENTRIES; i++) begin
            disp(i, i + 1, 0, 0, 'h100 + i, i * 16, 'h1000 + 4 * i, i + 1, 1);
            step();
        end
        idle();
        check("t4_full_count", bus.count, ENTRIES);
        check("t4_full_no_cap", bus.has_capacity, 0);
        check("t4_held_valid", bus.out_valid, 1);
        check("t4_held_op", bus.out_op, 'h3F);
        disp('h2A, 0, 0, 1, 1, 0, 0, 0, 0);
        step();
        idle();
        check("t4_drop_count", bus.count, ENTRIES);
        check("t4_drop_op", bus.out_op, 'h3F);
        // Invalid buses must not wake anything.
        bus.cdb_tag  = {ROB_W'(2), ROB_W'(1)};
        bus.cdb_data = {DATA_W'('hBEEF), DATA_W'('hDEAD)};
        step();
        idle();
        check("t4_hold_op_invalid_cdb", bus.out_op, 'h3F);
        // Release in reverse dispatch order while the output stays stalled.
        for (int r = 0; r < 4; r++) begin
            set_cdb(0, 8 - 2 * r, 'hA000 + 8 - 2 * r);
            set_cdb(1, 7 - 2 * r, 'hA000 + 7 - 2 * r);
            step();
            idle();
            check("t5_hold_op", bus.out_op, 'h3F);
            check("t5_hold_vj", bus.out_Vj, 'h55);
            check("t5_hold_pc", bus.out_pc, 'h88);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < ENTRIES; i++) begin
            step();
            check("t4_issue_valid", bus.out_valid, 1);
            check("t4_issue_op", bus.out_op, i);
            check("t4_issue_vj", bus.out_Vj, 'hA000 + i + 1);
            check("t4_issue_vk", bus.out_Vk, 'h100 + i);
            check("t4_issue_imm", bus.out_imm, i * 16);
            check("t4_issue_pc", bus.out_pc, 'h1000 + 4 * i);
            check("t4_issue_rob", bus.out_rob_tag, i + 1);
            check("t4_issue_count", bus.count, ENTRIES - 1 - i);
            check("t4_issue_cap", bus.has_capacity, 1);
        end
        step();
        check("t4_empty_valid", bus.out_valid, 0);
        check("t4_empty_count", bus.count, 0);

        // Flush with four entries held and a stalled output.
        bus.out_ready = 1'b0;
        disp('h21, 0, 0, 3, 4, 0, 0, 1, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            disp('h20, 9, 0, 0, 0, 0, 0, 2, 1);
            step();
        end
        idle();
        check("t6_pre_count", bus.count, 4);
        check("t6_pre_valid", bus.out_valid, 1);
        check("t6_pre_op", bus.out_op, 'h21);
        bus.flush = 1'b1;
        disp('h22, 0, 0, 1, 1, 0, 0, 3, 1);
        step();
        idle();
        check("t6_flush_count", bus.count, 0);
        check("t6_flush_valid", bus.out_valid, 0);
        check("t6_flush_cap", bus.has_capacity, 1);
        step();
        check("t6_no_write_count", bus.count, 0);
        check("t6_no_write_valid", bus.out_valid, 0);
        set_cdb(0, 9, 'h99);
        step();
        idle();
        step();
        check("t6_no_stale_valid", bus.out_valid, 0);
        check("t6_no_stale_count", bus.count, 0);

        // Back-to-back dispatch and issue at full rate.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) disp('h10 + i, 0, 0, i, i, 0, 0, 1, 1);
            else       idle();
            step();
            if (i == 0) begin
                check("t7_first_valid", bus.out_valid, 0);
                check("t7_first_count", bus.count, 1);
            end else begin
                check("t7_valid", bus.out_valid, 1);
                check("t7_op", bus.out_op, 'h10 + i - 1);
                check("t7_count", bus.count, (i < 3) ? 1 : 0);
            end
        end
        idle();
        step();
        check("t7_drain", bus.out_valid, 0);

        // Reset while the output is stalled drops it and clears the fields.
        bus.out_ready = 1'b0;
        disp('h30, 0, 0, 'hAB, 'hCD, 0, 0, 4, 1);
        step();
        idle();
        step();
        check("t8_pre_valid", bus.out_valid, 1);
        check("t8_pre_op", bus.out_op, 'h30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t8_rst_valid", bus.out_valid, 0);
        check("t8_rst_op", bus.out_op, 0);
        check("t8_rst_vj", bus.out_Vj, 0);
        check("t8_rst_count", bus.count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
